// File: rtl/axis_frame_fifo.sv
// axis_frame_fifo: single-clock AXI4-Stream store-and-forward frame FIFO.
// A frame becomes visible at the output only after its tlast beat is stored;
// bad frames (tuser on tlast) and frames that run out of space are discarded whole.
module axis_frame_fifo #(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned KEEP_ENABLE    = 0,
  parameter int unsigned KEEP_WIDTH     = (DATA_WIDTH + 7) / 8,
  parameter int unsigned DROP_WHEN_FULL = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] input_axis_tkeep,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  input  logic                  input_axis_tlast,
  input  logic                  input_axis_tuser,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic [KEEP_WIDTH-1:0] output_axis_tkeep,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic                  status_overflow,
  output logic                  status_bad_frame,
  output logic                  status_good_frame,
  output logic [ADDR_WIDTH:0]   status_count
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [PTR_W-1:0] DEPTH_P = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef struct packed {
    logic                  last;
    logic [KEEP_WIDTH-1:0] keep;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  beat_t mem [DEPTH];
  beat_t out_beat;

  logic [PTR_W-1:0] wr_ptr, wr_ptr_cur, rd_ptr;
  logic [PTR_W-1:0] wr_ptr_n, wr_ptr_cur_n;
  logic             drop_frame, drop_frame_n;
  logic             overflow_n, bad_frame_n, good_frame_n;
  logic             full_cur, full_wr, empty;
  logic             accept, store, read;

  assign full_cur = (wr_ptr_cur - rd_ptr) == DEPTH_P;
  assign full_wr  = (wr_ptr_cur - wr_ptr) == DEPTH_P;
  assign empty    = (rd_ptr == wr_ptr);

  // Stall only when full behind committed frames; a frame that alone fills the
  // buffer must keep flowing so its overflow beat can be seen and the rest dropped.
  assign input_axis_tready = (DROP_WHEN_FULL != 0) | ~full_cur | full_wr | drop_frame;
  assign accept            = input_axis_tvalid & input_axis_tready;
  assign read              = (output_axis_tready | ~output_axis_tvalid) & ~empty;

  // Write-side next state: store, commit, discard or overflow for the accepted beat.
  always_comb begin
    wr_ptr_n     = wr_ptr;
    wr_ptr_cur_n = wr_ptr_cur;
    drop_frame_n = drop_frame;
    overflow_n   = 1'b0;
    bad_frame_n  = 1'b0;
    good_frame_n = 1'b0;
    store        = 1'b0;
    if (accept) begin
      if (drop_frame) begin
        if (input_axis_tlast) drop_frame_n = 1'b0;
      end else if (full_cur) begin
        // Accepted while full only when dropping on full or the frame fills the buffer.
        wr_ptr_cur_n = wr_ptr;
        overflow_n   = 1'b1;
        if (!input_axis_tlast) drop_frame_n = 1'b1;
      end else begin
        store        = 1'b1;
        wr_ptr_cur_n = wr_ptr_cur + PTR_W'(1);
        if (input_axis_tlast) begin
          if (input_axis_tuser) begin
            wr_ptr_cur_n = wr_ptr;
            bad_frame_n  = 1'b1;
          end else begin
            wr_ptr_n     = wr_ptr_cur + PTR_W'(1);
            good_frame_n = 1'b1;
          end
        end
      end
    end
  end

  // Pointer, drop flag, status and output-valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr             <= '0;
      wr_ptr_cur         <= '0;
      rd_ptr             <= '0;
      drop_frame         <= 1'b0;
      status_overflow    <= 1'b0;
      status_bad_frame   <= 1'b0;
      status_good_frame  <= 1'b0;
      status_count       <= '0;
      output_axis_tvalid <= 1'b0;
    end else begin
      wr_ptr            <= wr_ptr_n;
      wr_ptr_cur        <= wr_ptr_cur_n;
      drop_frame        <= drop_frame_n;
      status_overflow   <= overflow_n;
      status_bad_frame  <= bad_frame_n;
      status_good_frame <= good_frame_n;
      status_count      <= wr_ptr - rd_ptr;
      if (read) rd_ptr <= rd_ptr + PTR_W'(1);
      if (output_axis_tready | ~output_axis_tvalid) output_axis_tvalid <= ~empty;
    end
  end

  // Beat storage at the speculative write pointer.
  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr_cur[ADDR_WIDTH-1:0]] <= '{last: input_axis_tlast,
                                           keep: input_axis_tkeep,
                                           data: input_axis_tdata};
    end
  end

  // Output register; holds its beat while the consumer stalls.
  always_ff @(posedge clk) begin
    if (read) out_beat <= mem[rd_ptr[ADDR_WIDTH-1:0]];
  end

  assign output_axis_tdata = out_beat.data;
  assign output_axis_tlast = out_beat.last;
  assign output_axis_tkeep = (KEEP_ENABLE != 0) ? out_beat.keep : {KEEP_WIDTH{1'b1}};

endmodule
